bldc_commutator: RTL

Six-step commutation controller for a three-phase BLDC motor. It sequences the three per-phase PWM drivers, one for each of phases A, B and C:
- Filters the hall sensor inputs.
- Decodes the rotor sector.
- Slew-limits the commanded duty cycle.
- Drives each phase driver's `duty_cycle` and `high_z` inputs.
- Handles brake, invalid-hall and stall faults.

It sits between the motor command interface (registers or SPI) and the three phase drivers.

---
 rtl/bldc_pkg.sv | 59 +++++
 rtl/bldc_commutator_hall_filter.sv | 53 +++++
 rtl/bldc_commutator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bldc_pkg.sv
// Shared types and helpers for the six-step BLDC commutation controller.
package bldc_pkg;

    // Controller state, encoded as reported on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Fault codes held while in FAULT.
    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_HALL  = 2'd1;
    localparam logic [1:0] FC_STALL = 2'd2;

    // Role a phase plays within the current sector.
    typedef enum logic [1:0] {
        ROLE_PWM   = 2'd0,
        ROLE_LOW   = 2'd1,
        ROLE_FLOAT = 2'd2
    } role_e;

    typedef struct packed {
        role_e a;
        role_e b;
        role_e c;
    } roles_t;

    // Codes 0 and 7 cannot occur with healthy 120-degree sensors.
    function automatic logic hall_valid(input logic [2:0] h);
        return (h != 3'd0) && (h != 3'd7);
    endfunction

    // Sector table: the forward table drives the listed phase with PWM and
    // holds the second low; reverse swaps those two roles. Invalid codes
    // float every phase.
    function automatic roles_t sector_roles(input logic [2:0] h, input logic rev);
        role_e  hi;
        role_e  lo;
        roles_t r;
        hi = rev ? ROLE_LOW : ROLE_PWM;
        lo = rev ? ROLE_PWM : ROLE_LOW;
        r.a = ROLE_FLOAT;
        r.b = ROLE_FLOAT;
        r.c = ROLE_FLOAT;
        case (h)
            3'd5: begin r.a = hi; r.b = lo; end
            3'd4: begin r.a = hi; r.c = lo; end
            3'd6: begin r.b = hi; r.c = lo; end
            3'd2: begin r.b = hi; r.a = lo; end
            3'd3: begin r.c = hi; r.a = lo; end
            3'd1: begin r.c = hi; r.b = lo; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall input conditioning: two-flop synchronizer followed by a debounce
// counter. A code is accepted into hall_f only after HALL_FILTER consecutive
// identical synchronized samples; hall_change pulses for one cycle with it.
module hall_filter #(
    parameter int HALL_FILTER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    output logic [2:0] hall_f,
    output logic       hall_change
);

    localparam int CW = $clog2(HALL_FILTER + 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Run length of the current synchronized code, including this sample,
    // saturating at the filter depth.
    always_comb begin
        cnt_next = CW'(1);
        if (sync2 == cand) begin
            cnt_next = (cnt == CW'(HALL_FILTER)) ? cnt : cnt + CW'(1);
        end
    end

    // Synchronizer, run-length tracking and acceptance of stable codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 3'd0;
            sync2       <= 3'd0;
            cand        <= 3'd0;
            cnt         <= '0;
            hall_f      <= 3'd0;
            hall_change <= 1'b0;
        end else begin
            sync1       <= hall;
            sync2       <= sync1;
            cand        <= sync2;
            cnt         <= cnt_next;
            hall_change <= 1'b0;
            if (cnt_next == CW'(HALL_FILTER) && sync2 != hall_f) begin
                hall_f      <= sync2;
                hall_change <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller: state machine, duty slew limiter,
// stall watchdog and per-phase driver outputs derived from the filtered hall
// sector. Outputs are registered from the next-state view so a decision made
// on one edge appears on the phase drivers at that same edge.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DUTY_CYCLE_WIDTH = 10,
    parameter int HALL_FILTER      = 4,
    parameter int SLEW_STEP        = 8,
    parameter int STALL_TIMEOUT    = 2000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        brake,
    input  logic                        direction,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cmd,
    input  logic [2:0]                  hall,
    input  logic                        period_strobe,
    input  logic                        clear_fault,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_a,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_b,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_c,
    output logic                        high_z_a,
    output logic                        high_z_b,
    output logic                        high_z_c,
    output logic [1:0]                  state,
    output logic [1:0]                  fault_code,
    output logic [15:0]                 comm_count
);

    localparam int DW = DUTY_CYCLE_WIDTH;
    localparam int SW = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_BRAKE = ST_BRAKE;
    localparam logic [1:0] S_FAULT = ST_FAULT;

    localparam logic [DW-1:0] STEP    = DW'(SLEW_STEP);
    localparam logic [SW-1:0] STALL_T = SW'(STALL_TIMEOUT);

    logic [2:0]          hall_f;
    logic                hall_change;
    logic [2:0]          hall_f_d;
    logic [1:0]          st_next;
    logic [1:0]          fc_next;
    logic [DW-1:0]       duty_applied;
    logic [DW-1:0]       slewed;
    logic [DW-1:0]       da_next;
    logic [SW-1:0]       stall_cnt;
    logic [SW-1:0]       stall_next;
    roles_t              roles;
    role_e               role_v [3];
    logic [2:0][DW-1:0]  duty_n;
    logic [2:0]          hz_n;

    hall_filter #(
        .HALL_FILTER (HALL_FILTER)
    ) u_hall_filter (
        .clk         (clk),
        .rst         (rst),
        .hall        (hall),
        .hall_f      (hall_f),
        .hall_change (hall_change)
    );

    // Next state and fault code, evaluated in fixed priority order.
    always_comb begin
        st_next = state;
        fc_next = fault_code;
        if (state == S_RUN && !hall_valid(hall_f)) begin
            st_next = S_FAULT;
            fc_next = FC_HALL;
        end else if (state == S_RUN && stall_cnt == STALL_T) begin
            st_next = S_FAULT;
            fc_next = FC_STALL;
        end else if (state != S_FAULT && brake) begin
            st_next = S_BRAKE;
        end else if (state != S_FAULT && !enable) begin
            st_next = S_IDLE;
        end else if ((state == S_IDLE || state == S_BRAKE) && enable && hall_valid(hall_f)) begin
            st_next = S_RUN;
        end else if (state == S_FAULT && clear_fault && !enable) begin
            st_next = S_IDLE;
            fc_next = FC_NONE;
        end
    end

    // One slew step toward the command; the step is only added or removed
    // when the gap exceeds it, so the result can neither wrap nor overshoot.
    always_comb begin
        if (duty_cmd > duty_applied) begin
            slewed = (duty_cmd - duty_applied > STEP) ? duty_applied + STEP : duty_cmd;
        end else begin
            slewed = (duty_applied - duty_cmd > STEP) ? duty_applied - STEP : duty_cmd;
        end
    end

    // Applied duty only exists in RUN and only moves on a PWM period wrap.
    always_comb begin
        if (st_next != S_RUN) begin
            da_next = '0;
        end else if (state == S_RUN && period_strobe) begin
            da_next = slewed;
        end else begin
            da_next = duty_applied;
        end
    end

    // Stall watchdog: counts driven clocks without rotor progress, saturating.
    always_comb begin
        stall_next = stall_cnt;
        if (st_next != S_RUN || hall_change) begin
            stall_next = '0;
        end else if (duty_applied != '0 && stall_cnt != STALL_T) begin
            stall_next = stall_cnt + SW'(1);
        end
    end

    // Per-phase driver values for the state being entered.
    always_comb begin
        roles     = sector_roles(hall_f, direction);
        role_v[0] = roles.a;
        role_v[1] = roles.b;
        role_v[2] = roles.c;
        for (int i = 0; i < 3; i++) begin
            duty_n[i] = '0;
            hz_n[i]   = 1'b1;
            case (st_next)
                S_RUN: begin
                    duty_n[i] = (role_v[i] == ROLE_PWM) ? da_next : '0;
                    hz_n[i]   = (role_v[i] == ROLE_FLOAT);
                end
                S_BRAKE: hz_n[i] = 1'b0;
                default: ;
            endcase
        end
    end

    // Core state: FSM, fault code, applied duty and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            fault_code   <= FC_NONE;
            duty_applied <= '0;
            stall_cnt    <= '0;
        end else begin
            state        <= st_next;
            fault_code   <= fc_next;
            duty_applied <= da_next;
            stall_cnt    <= stall_next;
        end
    end

    // Commutation counter: only transitions between two valid sectors count.
    always_ff @(posedge clk) begin
        if (rst) begin
            hall_f_d   <= 3'd0;
            comm_count <= '0;
        end else begin
            hall_f_d <= hall_f;
            if (hall_change && hall_valid(hall_f) && hall_valid(hall_f_d)) begin
                comm_count <= comm_count + 16'd1;
            end
        end
    end

    // Registered phase driver outputs; reset floats every phase at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_a   <= '0;
            duty_b   <= '0;
            duty_c   <= '0;
            high_z_a <= 1'b1;
            high_z_b <= 1'b1;
            high_z_c <= 1'b1;
        end else begin
            duty_a   <= duty_n[0];
            duty_b   <= duty_n[1];
            duty_c   <= duty_n[2];
            high_z_a <= hz_n[0];
            high_z_b <= hz_n[1];
            high_z_c <= hz_n[2];
        end
    end

endmodule
